// File: rtl/data_mem_lsu.sv
// Byte-addressed little-endian data memory behind a one-entry
// valid/ready response pipeline with alignment checking.
module data_mem_lsu #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             load_unsigned,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] rdata,
    output logic             resp_err,
    output logic [15:0]      err_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0]           r_mem [DEPTH];
    logic                 r_resp_valid;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_resp_err;
    logic [15:0]          r_err_count;

    logic [ADDR_BITS-1:0] w_a0;
    logic [ADDR_BITS-1:0] w_a1;
    logic [ADDR_BITS-1:0] w_a2;
    logic [ADDR_BITS-1:0] w_a3;
    logic                 w_accept;
    logic                 w_bad;
    logic                 w_store;
    logic [31:0]          w_raw;
    logic [31:0]          w_ext;
    logic                 w_unused_addr;

    assign w_a0 = addr[ADDR_BITS-1:0];
    assign w_a1 = w_a0 + ADDR_BITS'(1);
    assign w_a2 = w_a0 + ADDR_BITS'(2);
    assign w_a3 = w_a0 + ADDR_BITS'(3);
    assign w_unused_addr = ^addr[WIDTH-1:ADDR_BITS];

    assign req_ready  = !r_resp_valid || resp_ready;
    assign w_accept   = req_valid && req_ready && !rst;
    assign w_store    = w_accept && we && !w_bad;

    assign resp_valid = r_resp_valid;
    assign rdata      = r_rdata;
    assign resp_err   = r_resp_err;
    assign err_count  = r_err_count;

    always_comb begin
        w_bad = 1'b0;
        unique case (size)
            2'b00: w_bad = 1'b0;
            2'b01: w_bad = w_a0[0];
            2'b10: w_bad = |w_a0[1:0];
            2'b11: w_bad = 1'b1;
        endcase
    end

    assign w_raw = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};

    // Word loads pass through; narrower loads extend their top bit unless unsigned.
    always_comb begin
        w_ext = w_raw;
        unique case (size)
            2'b00: w_ext = load_unsigned ? {24'd0, w_raw[7:0]}
                                         : {{24{w_raw[7]}}, w_raw[7:0]};
            2'b01: w_ext = load_unsigned ? {16'd0, w_raw[15:0]}
                                         : {{16{w_raw[15]}}, w_raw[15:0]};
            2'b10: w_ext = w_raw;
            2'b11: w_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            unique case (size)
                2'b00: r_mem[w_a0] <= wdata[7:0];
                2'b01: begin
                    r_mem[w_a0] <= wdata[7:0];
                    r_mem[w_a1] <= wdata[15:8];
                end
                2'b10: begin
                    r_mem[w_a0] <= wdata[7:0];
                    r_mem[w_a1] <= wdata[15:8];
                    r_mem[w_a2] <= wdata[23:16];
                    r_mem[w_a3] <= wdata[31:24];
                end
                2'b11: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_resp_err   <= 1'b0;
            r_err_count  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_bad;
                r_rdata      <= (we || w_bad) ? '0 : WIDTH'(w_ext);
                if (w_bad && r_err_count != 16'hFFFF)
                    r_err_count <= r_err_count + 16'd1;
            end else if (r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomised and directed checks of data_mem_lsu against a
// byte-array reference model.
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rdata;
    logic        resp_err;
    logic [15:0] err_count;

    int vectors;
    int miscompares;
    int exp_errcnt;
    logic [7:0] mm [int];

    logic        obs_v;
    logic [31:0] obs_rd;
    logic        obs_err;
    logic [15:0] obs_cnt;

    data_mem_lsu #(.WIDTH(32), .ADDR_BITS(17)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .we(we), .size(size), .load_unsigned(load_unsigned),
        .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .rdata(rdata), .resp_err(resp_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_req(input logic we_i, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a,
                             input logic [31:0] wd,
                             output logic [31:0] er, output logic ee);
        int ma, nb;
        logic [31:0] val, mask;
        ma = int'(a & 32'h1FFFF);
        nb = 1 << sz;
        er = 32'd0;
        ee = (sz == 2'd3) || ((ma % nb) != 0);
        if (ee) begin
            if (exp_errcnt < 65535) exp_errcnt++;
        end else if (we_i) begin
            for (int i = 0; i < nb; i++) mm[ma + i] = 8'(wd >> (8 * i));
        end else begin
            val = 32'd0;
            for (int i = 0; i < nb; i++)
                if (mm.exists(ma + i)) val = val | (32'(mm[ma + i]) << (8 * i));
            if (nb < 4) begin
                mask = (32'd1 << (8 * nb)) - 32'd1;
                if (!uns && val[8 * nb - 1]) val = val | ~mask;
            end
            er = val;
        end
    endtask

    task automatic issue(input logic we_i, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; resp_ready = 1'b1;
        we = we_i; size = sz; load_unsigned = uns;
        addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        obs_v = resp_valid; obs_rd = rdata;
        obs_err = resp_err; obs_cnt = err_count;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        we = 1'b0; size = 2'd0; load_unsigned = 1'b0;
        addr = '0; wdata = '0;
        #3;
        vectors++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || rdata !== 32'd0 ||
            err_count !== 16'd0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: v=%b e=%b rd=%h cnt=%h rdy=%b required 0 0 0 0 1",
                     resp_valid, resp_err, rdata, err_count, req_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_errcnt = 0;
    endtask

    task automatic test_directed;
        logic [31:0] er; logic ee;
        struct packed {logic w; logic [1:0] s; logic u; logic [31:0] a;
                       logic [31:0] d; logic [31:0] xr; logic xe; logic [15:0] xc;} t [7];
        t[0] = {1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 16'd0};
        t[1] = {1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, 16'd0};
        t[2] = {1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 16'd0};
        t[3] = {1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 16'd0};
        t[4] = {1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 32'h0, 1'b1, 16'd1};
        t[5] = {1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 16'd1};
        t[6] = {1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 16'd2};
        for (int i = 0; i < 7; i++) begin
            model_req(t[i].w, t[i].s, t[i].u, t[i].a, t[i].d, er, ee);
            issue(t[i].w, t[i].s, t[i].u, t[i].a, t[i].d);
            vectors++;
            if (obs_v !== 1'b1 || obs_rd !== t[i].xr || obs_err !== t[i].xe ||
                obs_cnt !== t[i].xc || er !== t[i].xr) begin
                miscompares++;
                $display("FAIL directed[%0d]: v=%b rd=%h err=%b cnt=%0d required 1 %h %b %0d",
                         i, obs_v, obs_rd, obs_err, obs_cnt, t[i].xr, t[i].xe, t[i].xc);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] er, a, d; logic ee, w, u; logic [1:0] s;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            a = 32'h200 + 32'(4 * i);
            model_req(1'b1, 2'd2, 1'b0, a, d, er, ee);
            issue(1'b1, 2'd2, 1'b0, a, d);
        end
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            a = {15'($urandom), 17'(32'h200 + $urandom_range(0, 255))};
            d = $urandom;
            model_req(w, s, u, a, d, er, ee);
            issue(w, s, u, a, d);
            vectors++;
            if (obs_v !== 1'b1 || obs_rd !== er || obs_err !== ee ||
                obs_cnt !== 16'(exp_errcnt)) begin
                miscompares++;
                $display("FAIL random[%0d] we=%b sz=%0d a=%h: rd=%h err=%b cnt=%0d required %h %b %0d",
                         i, w, s, a, obs_rd, obs_err, obs_cnt, er, ee, exp_errcnt);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] ea, eb, snap; logic ee;
        model_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, ea, ee);
        model_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, eb, ee);
        @(negedge clk);
        req_valid = 1'b1; resp_ready = 1'b0;
        we = 1'b0; size = 2'd2; load_unsigned = 1'b0; addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        size = 2'd1; addr = 32'h102;
        snap = rdata;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || rdata !== ea ||
                rdata !== snap) begin
                miscompares++;
                $display("FAIL stall[%0d]: v=%b rdy=%b rd=%h required 1 0 %h",
                         k, resp_valid, req_ready, rdata, ea);
            end
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: rdy=%b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b1 || rdata !== eb || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL release_resp: v=%b rd=%h required 1 %h", resp_valid, rdata, eb);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: v=%b required 0", resp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [$];
        logic [31:0] er, a; logic ee, u; logic [1:0] s;
        resp_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (resp_valid !== 1'b1 || rdata !== exp_q[0] || req_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: v=%b rd=%h rdy=%b required 1 %h 1",
                             i - 1, resp_valid, rdata, req_ready, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (i < 8) begin
                s = 2'($urandom_range(0, 2));
                u = 1'($urandom_range(0, 1));
                a = 32'h200 + (32'($urandom_range(0, 63)) << s);
                model_req(1'b0, s, u, a, 32'h0, er, ee);
                exp_q.push_back(er);
                req_valid = 1'b1; we = 1'b0; size = s;
                load_unsigned = u; addr = a;
                @(posedge clk);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        req_valid = 1'b1; resp_ready = 1'b1;
        we = 1'b0; size = 2'd3; addr = 32'h100;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        exp_errcnt = (exp_errcnt + 65536 > 65535) ? 65535 : exp_errcnt + 65536;
        vectors++;
        if (err_count !== 16'(exp_errcnt) || resp_err !== 1'b1 || rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL saturate: cnt=%h err=%b rd=%h required %h 1 0",
                     err_count, resp_err, rdata, 16'(exp_errcnt));
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; resp_ready = 1'b0;
        we = 1'b0; size = 2'd2; addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        req_valid = 1'b1; we = 1'b1; size = 2'd2;
        addr = 32'h100; wdata = 32'h12345678;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || err_count !== 16'd0 || req_ready !== 1'b1 ||
            rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL async_rst: v=%b cnt=%h rdy=%b rd=%h required 0 0 1 0",
                     resp_valid, err_count, req_ready, rdata);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0;
        exp_errcnt = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        vectors++;
        if (obs_v !== 1'b1 || obs_rd !== 32'hDEADBEEF || obs_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL retained: v=%b rd=%h cnt=%0d required 1 deadbeef 0",
                     obs_v, obs_rd, obs_cnt);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_errcnt = 0;
        test_reset;
        test_directed;
        test_backpressure;
        test_random;
        test_back_to_back;
        test_saturation;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, fixed at 32; other values are unsupported.
REQ-002 SHALL have parameter ADDR_BITS, default 17: byte-address bits used; the array holds 2**ADDR_BITS bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port size, input, 2 bits: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port load_unsigned, input, 1 bit: 1 = zero-extend load data, 0 = sign-extend.
REQ-010 SHALL have port addr, input, WIDTH bits: byte address; bits above ADDR_BITS-1 are ignored.
REQ-011 SHALL have port wdata, input, WIDTH bits: store data, least-significant bytes used.
REQ-012 SHALL have port resp_valid, output, 1 bit: the response is valid.
REQ-013 SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-014 SHALL have port rdata, output, WIDTH bits: load result, already extended.
REQ-015 SHALL have port resp_err, output, 1 bit: the request was misaligned or illegal.
REQ-016 SHALL have port err_count, output, 16 bits: saturating count of errored requests.

Function
REQ-017 SHALL store data little-endian in a byte-wide array: byte addr holds bits [7:0], addr+1 holds [15:8], and so on.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-019 SHALL drive req_ready = !resp_valid || resp_ready, combinationally; the block is a one-entry response pipeline.
REQ-020 SHALL assert resp_valid on the edge after an accepted request, with rdata and resp_err registered alongside it.
REQ-021 SHALL hold resp_valid, rdata and resp_err stable while resp_valid && !resp_ready.
REQ-022 SHALL clear resp_valid on an edge where resp_valid && resp_ready and no new request is accepted.
REQ-023 SHALL keep resp_valid at 1 and load the new response on an edge where the current response is consumed and a new request is accepted on the same edge; this gives one request per cycle sustained.
REQ-024 SHALL treat as misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=00. SHALL treat size=11 as illegal.
REQ-025 SHALL, for a misaligned or illegal request: perform no array write, set resp_err=1, set rdata=0, and increment err_count.
REQ-026 SHALL stop err_count at 0xFFFF; it does not wrap.
REQ-027 SHALL commit a legal store on its accept edge: byte writes wdata[7:0]; half writes [15:0] to addr and addr+1; word writes [31:0] to addr..addr+3.
REQ-028 SHALL, for a legal store response, set rdata=0 and resp_err=0.
REQ-029 SHALL sample array bytes for a legal load at its accept edge; byte loads extend bit 7, half loads extend bit 15, word loads pass through.
REQ-030 SHALL apply zero-extension when load_unsigned=1 and sign-extension when load_unsigned=0; load_unsigned is ignored for word loads and for stores.
REQ-031 SHALL let a load accepted on the edge after a store to the same bytes return the newly stored data.
REQ-032 SHALL NOT let a load sample a same-edge store; no same-edge overlap exists because only one request is accepted per edge.

Reset
REQ-033 SHALL, while rst=1, immediately force resp_valid=0, resp_err=0, rdata=0 and err_count=0, so req_ready=1.
REQ-034 SHALL NOT initialise array contents on reset.
REQ-035 SHALL discard a response pending at reset.
REQ-036 SHALL ignore a request presented while rst=1.

Verification
REQ-037 SHALL cover: store word 0xDEADBEEF at 0x100, then load byte signed at 0x101 -> rdata=0xFFFFFFBE, resp_err=0.
REQ-038 SHALL cover: load half unsigned at 0x102 after the REQ-037 store -> rdata=0x0000DEAD; load word at 0x100 -> 0xDEADBEEF.
REQ-039 SHALL cover: store word at 0x102 -> resp_err=1, no bytes changed (reread 0x100 = 0xDEADBEEF), err_count=1; size=11 -> err_count=2.
REQ-040 SHALL cover: hold resp_ready=0 for 3 cycles with a response pending -> req_ready=0, resp_valid and rdata stable; on release, the next request is accepted that edge.
REQ-041 SHALL cover: back-to-back loads with resp_ready=1 for 8 cycles -> 8 responses in 8 consecutive cycles, in order.
REQ-042 SHALL cover: rst asserted mid-response -> resp_valid=0 asynchronously, err_count=0, and stored data is retained after reset.
